// File: rtl/bus_arbiter_if.sv
// Master/device handshake bundle around bus_arbiter. The master modport is the arbiter's view
// (it drives the device bus); the slave modport is the view of the masters and devices around it.
interface bus_arbiter_if;
  logic        m0_req;
  logic        m0_wr;
  logic [31:0] m0_addr;
  logic [31:0] m0_wdata;
  logic [31:0] m0_rdata;
  logic        m0_ack;
  logic        m0_err;

  logic        m1_req;
  logic        m1_wr;
  logic [31:0] m1_addr;
  logic [31:0] m1_wdata;
  logic [31:0] m1_rdata;
  logic        m1_ack;
  logic        m1_err;

  logic        bus_req;
  logic        bus_wr;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ack;
  logic        bus_hit;

  modport master (
    input  m0_req, m0_wr, m0_addr, m0_wdata,
    output m0_rdata, m0_ack, m0_err,
    input  m1_req, m1_wr, m1_addr, m1_wdata,
    output m1_rdata, m1_ack, m1_err,
    output bus_req, bus_wr, bus_addr, bus_wdata,
    input  bus_rdata, bus_ack, bus_hit
  );

  modport slave (
    output m0_req, m0_wr, m0_addr, m0_wdata,
    input  m0_rdata, m0_ack, m0_err,
    output m1_req, m1_wr, m1_addr, m1_wdata,
    input  m1_rdata, m1_ack, m1_err,
    input  bus_req, bus_wr, bus_addr, bus_wdata,
    output bus_rdata, bus_ack, bus_hit
  );
endinterface

// File: rtl/bus_arbiter.sv
// Two-master round-robin arbiter and single-outstanding sequencer for the device bus,
// with unmapped-address and ack-timeout error responses.
module bus_arbiter #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          rst,
  bus_arbiter_if.master bus
);

  typedef enum logic [1:0] {StIdle, StBus, StResp} state_e;

  localparam logic [7:0] CntLimit = 8'(TIMEOUT - 1);

  state_e      state_q;
  logic        grant_q;
  logic        last_q;
  logic [7:0]  cnt_q;
  logic        err_q;
  logic [31:0] rdata_q;
  logic        bus_wr_q;
  logic [31:0] bus_addr_q;
  logic [31:0] bus_wdata_q;

  logic req_any;
  logic pick;

  assign req_any = bus.m0_req | bus.m1_req;
  // A tie goes to the master that was not served last.
  assign pick    = (bus.m0_req & bus.m1_req) ? ~last_q : bus.m1_req;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      grant_q     <= 1'b0;
      last_q      <= 1'b1;
      cnt_q       <= 8'd0;
      err_q       <= 1'b0;
      rdata_q     <= 32'd0;
      bus_wr_q    <= 1'b0;
      bus_addr_q  <= 32'd0;
      bus_wdata_q <= 32'd0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req_any) begin
            grant_q     <= pick;
            last_q      <= pick;
            cnt_q       <= 8'd0;
            bus_wr_q    <= pick ? bus.m1_wr    : bus.m0_wr;
            bus_addr_q  <= pick ? bus.m1_addr  : bus.m0_addr;
            bus_wdata_q <= pick ? bus.m1_wdata : bus.m0_wdata;
            state_q     <= StBus;
          end
        end
        StBus: begin
          // The decoders only get the first cycle to claim the address; an ack then is ignored.
          if (cnt_q == 8'd0 && !bus.bus_hit) begin
            err_q   <= 1'b1;
            state_q <= StResp;
          end else if (bus.bus_ack) begin
            rdata_q <= bus.bus_rdata;
            err_q   <= 1'b0;
            state_q <= StResp;
          end else if (cnt_q == CntLimit) begin
            err_q   <= 1'b1;
            state_q <= StResp;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        StResp: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign bus.bus_req   = (state_q == StBus);
  assign bus.bus_wr    = bus_wr_q;
  assign bus.bus_addr  = bus_addr_q;
  assign bus.bus_wdata = bus_wdata_q;

  always_comb begin
    bus.m0_ack   = 1'b0;
    bus.m0_err   = 1'b0;
    bus.m0_rdata = 32'd0;
    bus.m1_ack   = 1'b0;
    bus.m1_err   = 1'b0;
    bus.m1_rdata = 32'd0;
    if (state_q == StResp) begin
      if (!grant_q) begin
        bus.m0_ack   = ~err_q;
        bus.m0_err   = err_q;
        bus.m0_rdata = rdata_q;
      end else begin
        bus.m1_ack   = ~err_q;
        bus.m1_err   = err_q;
        bus.m1_rdata = rdata_q;
      end
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: latency, round-robin, unmapped, timeout and reset cases.
module tb_bus_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;

  int          ack_wait  = 0;  // BUS cycle (0-based) on which the device acks; -1 = never
  logic [31:0] dev_rdata = 32'd0;
  logic [7:0]  bus_cyc;

  bus_arbiter_if ifc ();

  bus_arbiter #(.TIMEOUT(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  always #5 clk = ~clk;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) bus_cyc <= 8'd0;
    else if (ifc.bus_req) bus_cyc <= bus_cyc + 8'd1;
    else bus_cyc <= 8'd0;
  end

  assign ifc.bus_ack   = ifc.bus_req && (ack_wait >= 0) && (bus_cyc == 8'(ack_wait));
  assign ifc.bus_rdata = dev_rdata;
  assign ifc.bus_hit   = (ifc.bus_addr[31:16] != 16'hFFFF);

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) step();
    tests++;
    if (ifc.bus_req !== 1'b0) begin
      fails++; $display("FAIL reset_bus_req: got %b expected 0", ifc.bus_req);
    end
    tests++;
    if ({ifc.m0_ack, ifc.m0_err, ifc.m1_ack, ifc.m1_err} !== 4'b0) begin
      fails++; $display("FAIL reset_ack_err: got %b expected 0000",
                        {ifc.m0_ack, ifc.m0_err, ifc.m1_ack, ifc.m1_err});
    end
    tests++;
    if ({ifc.bus_wr, ifc.bus_addr, ifc.bus_wdata} !== 65'd0) begin
      fails++; $display("FAIL reset_bus_regs: got wr=%b addr=%h wdata=%h expected 0",
                        ifc.bus_wr, ifc.bus_addr, ifc.bus_wdata);
    end
    tests++;
    if ({ifc.m0_rdata, ifc.m1_rdata} !== 64'd0) begin
      fails++; $display("FAIL reset_rdata: got %h %h expected 0", ifc.m0_rdata, ifc.m1_rdata);
    end
    rst = 1'b0;
    step();
    tests++;
    if (ifc.bus_req !== 1'b0) begin
      fails++; $display("FAIL idle_no_req: got bus_req=%b expected 0", ifc.bus_req);
    end
  endtask

  task automatic test_single_read();
    int breq = 0;
    int ack_at = -1;
    logic [31:0] rd = 32'd0;
    logic m1a = 1'b0;
    ack_wait = 0;
    dev_rdata = 32'hDEADBEEF;
    ifc.m0_wr = 1'b0; ifc.m0_addr = 32'h0000_1000; ifc.m0_req = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      step();
      if (ifc.bus_req) breq++;
      if (ifc.m1_ack) m1a = 1'b1;
      if (c == 1) begin
        tests++;
        if (ifc.bus_addr !== 32'h0000_1000 || ifc.bus_req !== 1'b1) begin
          fails++; $display("FAIL read_bus_addr: got req=%b addr=%h expected 1 00001000",
                            ifc.bus_req, ifc.bus_addr);
        end
      end
      if (ifc.m0_ack && ack_at < 0) begin
        ack_at = c; rd = ifc.m0_rdata; ifc.m0_req = 1'b0;
      end
    end
    ifc.m0_req = 1'b0;
    tests++;
    if (ack_at != 2) begin fails++; $display("FAIL read_ack_cycle: got %0d expected 2", ack_at); end
    tests++;
    if (rd !== 32'hDEADBEEF) begin fails++; $display("FAIL read_rdata: got %h expected deadbeef", rd); end
    tests++;
    if (breq != 1) begin fails++; $display("FAIL read_bus_req_len: got %0d expected 1", breq); end
    tests++;
    if (m1a !== 1'b0) begin fails++; $display("FAIL read_m1_ack: got %b expected 0", m1a); end
  endtask

  task automatic test_simultaneous();
    int a0 = -1;
    int a1 = -1;
    int acks = 0;
    rst = 1'b1; step(); rst = 1'b0;
    ack_wait = 0;
    ifc.m0_wr = 1'b0; ifc.m0_addr = 32'h0000_2000;
    ifc.m1_wr = 1'b0; ifc.m1_addr = 32'h0000_3000;
    ifc.m0_req = 1'b1; ifc.m1_req = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      step();
      if (ifc.m0_ack && a0 < 0) begin a0 = c; ifc.m0_req = 1'b0; end
      if (ifc.m1_ack && a1 < 0) begin a1 = c; ifc.m1_req = 1'b0; end
    end
    ifc.m0_req = 1'b0; ifc.m1_req = 1'b0;
    tests++;
    if (a0 != 2) begin fails++; $display("FAIL tie_m0_ack: got %0d expected 2", a0); end
    tests++;
    if (a1 != 5) begin fails++; $display("FAIL tie_m1_ack: got %0d expected 5", a1); end
    // m1 was served last, so the next tie belongs to m0 again.
    ifc.m0_req = 1'b1; ifc.m1_req = 1'b1;
    step();
    tests++;
    if (ifc.bus_addr !== 32'h0000_2000) begin
      fails++; $display("FAIL tie2_grant: got addr %h expected 00002000", ifc.bus_addr);
    end
    for (int c = 0; c < 10; c++) begin
      if (ifc.m0_ack) begin acks++; ifc.m0_req = 1'b0; end
      if (ifc.m1_ack) begin acks++; ifc.m1_req = 1'b0; end
      step();
    end
    tests++;
    if (acks != 2) begin fails++; $display("FAIL tie2_acks: got %0d expected 2", acks); end
  endtask

  task automatic test_back_to_back();
    int n = 0;
    int starts[6];
    logic [31:0] addrs[6];
    logic prev = 1'b0;
    logic [31:0] exp_addr;
    ack_wait = 0;
    ifc.m0_wr = 1'b0; ifc.m0_addr = 32'h0000_0A00;
    ifc.m1_wr = 1'b1; ifc.m1_addr = 32'h0000_0B00; ifc.m1_wdata = 32'h5555_AAAA;
    ifc.m0_req = 1'b1; ifc.m1_req = 1'b1;
    for (int c = 1; c <= 40 && n < 6; c++) begin
      step();
      if (ifc.bus_req && !prev) begin starts[n] = c; addrs[n] = ifc.bus_addr; n++; end
      prev = ifc.bus_req;
    end
    ifc.m0_req = 1'b0; ifc.m1_req = 1'b0;
    tests++;
    if (n != 6) begin fails++; $display("FAIL b2b_count: got %0d expected 6", n); end
    for (int i = 0; i < n; i++) begin
      exp_addr = (i % 2 == 0) ? 32'h0000_0A00 : 32'h0000_0B00;
      tests++;
      if (addrs[i] !== exp_addr) begin
        fails++; $display("FAIL b2b_addr[%0d]: got %h expected %h", i, addrs[i], exp_addr);
      end
    end
    for (int i = 1; i < n; i++) begin
      tests++;
      if (starts[i] - starts[i-1] != 3) begin
        fails++; $display("FAIL b2b_period[%0d]: got %0d expected 3", i, starts[i] - starts[i-1]);
      end
    end
    repeat (4) step();
  endtask

  task automatic test_unmapped_write();
    int breq = 0;
    int err_at = -1;
    logic m1a = 1'b0;
    ack_wait = 0;
    ifc.m1_wr = 1'b1; ifc.m1_addr = 32'hFFFF_0000; ifc.m1_wdata = 32'h1234_5678;
    ifc.m1_req = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      step();
      if (ifc.bus_req) breq++;
      if (ifc.m1_ack) m1a = 1'b1;
      if (c == 1) begin
        tests++;
        if (ifc.bus_wr !== 1'b1 || ifc.bus_wdata !== 32'h1234_5678) begin
          fails++; $display("FAIL unmapped_bus_wr: got wr=%b wdata=%h expected 1 12345678",
                            ifc.bus_wr, ifc.bus_wdata);
        end
      end
      if (ifc.m1_err && err_at < 0) begin err_at = c; ifc.m1_req = 1'b0; end
    end
    ifc.m1_req = 1'b0;
    tests++;
    if (err_at != 2) begin fails++; $display("FAIL unmapped_err_cycle: got %0d expected 2", err_at); end
    tests++;
    if (m1a !== 1'b0) begin fails++; $display("FAIL unmapped_ack: got %b expected 0", m1a); end
    tests++;
    if (breq != 1) begin fails++; $display("FAIL unmapped_bus_req_len: got %0d expected 1", breq); end
  endtask

  task automatic test_timeout();
    int breq;
    int err_at;
    int ack_at;
    logic [31:0] rd;
    for (int pass = 0; pass < 2; pass++) begin
      breq = 0; err_at = -1; ack_at = -1; rd = 32'd0;
      ack_wait = (pass == 0) ? -1 : 3;
      dev_rdata = 32'hCAFE_F00D;
      ifc.m0_wr = 1'b0; ifc.m0_addr = 32'h0000_4000; ifc.m0_req = 1'b1;
      for (int c = 1; c <= 8; c++) begin
        step();
        if (ifc.bus_req) breq++;
        if (ifc.m0_err && err_at < 0) begin err_at = c; ifc.m0_req = 1'b0; end
        if (ifc.m0_ack && ack_at < 0) begin ack_at = c; rd = ifc.m0_rdata; ifc.m0_req = 1'b0; end
      end
      ifc.m0_req = 1'b0;
      tests++;
      if (breq != 4) begin fails++; $display("FAIL timeout%0d_bus_req_len: got %0d expected 4", pass, breq); end
      if (pass == 0) begin
        tests++;
        if (err_at != 5 || ack_at != -1) begin
          fails++; $display("FAIL timeout_err: got err@%0d ack@%0d expected err@5 ack@-1", err_at, ack_at);
        end
      end else begin
        tests++;
        if (ack_at != 5 || err_at != -1) begin
          fails++; $display("FAIL late_ack: got ack@%0d err@%0d expected ack@5 err@-1", ack_at, err_at);
        end
        tests++;
        if (rd !== 32'hCAFE_F00D) begin fails++; $display("FAIL late_ack_rdata: got %h expected cafef00d", rd); end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic resp = 1'b0;
    ack_wait = -1;
    ifc.m0_wr = 1'b0; ifc.m0_addr = 32'h0000_5000;
    ifc.m1_wr = 1'b0; ifc.m1_addr = 32'h0000_6000;
    ifc.m0_req = 1'b1;
    step();
    step();
    tests++;
    if (ifc.bus_req !== 1'b1) begin fails++; $display("FAIL rstmid_in_bus: got %b expected 1", ifc.bus_req); end
    rst = 1'b1;
    #1;
    tests++;
    if (ifc.bus_req !== 1'b0) begin fails++; $display("FAIL rstmid_async_drop: got %b expected 0", ifc.bus_req); end
    for (int c = 0; c < 3; c++) begin
      if (ifc.m0_ack | ifc.m0_err | ifc.m1_ack | ifc.m1_err) resp = 1'b1;
      step();
    end
    ifc.m1_req = 1'b1;
    rst = 1'b0;
    ack_wait = 0;
    step();
    tests++;
    if (ifc.bus_addr !== 32'h0000_5000 || ifc.bus_req !== 1'b1) begin
      fails++; $display("FAIL rstmid_tie_grant: got req=%b addr=%h expected 1 00005000",
                        ifc.bus_req, ifc.bus_addr);
    end
    if (ifc.m0_ack | ifc.m0_err | ifc.m1_ack | ifc.m1_err) resp = 1'b1;
    tests++;
    if (resp !== 1'b0) begin fails++; $display("FAIL rstmid_no_resp: got %b expected 0", resp); end
    for (int c = 0; c < 10; c++) begin
      if (ifc.m0_ack) ifc.m0_req = 1'b0;
      if (ifc.m1_ack) ifc.m1_req = 1'b0;
      step();
    end
    ifc.m0_req = 1'b0; ifc.m1_req = 1'b0;
  endtask

  initial begin
    ifc.m0_req = 1'b0; ifc.m0_wr = 1'b0; ifc.m0_addr = 32'd0; ifc.m0_wdata = 32'd0;
    ifc.m1_req = 1'b0; ifc.m1_wr = 1'b0; ifc.m1_addr = 32'd0; ifc.m1_wdata = 32'd0;
    test_reset();
    test_single_read();
    test_simultaneous();
    test_back_to_back();
    test_unmapped_write();
    test_timeout();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
